// File: rtl/hex_image_writer.sv
// hex_image_writer
//   Parses an init-file style ASCII hex stream, one character per rx handshake,
//   into DATA_WIDTH words. Each word is written to an info/data RAM through a
//   registered write strobe at an auto-incrementing address.
//
//   Stream grammar:
//     hex digits       shift into the current word (last ND digits kept)
//     space/TAB/CR/LF  terminate a pending word (runs of whitespace are legal)
//     '@' hex... sep   set the write address for the following words
//     '#'              end of image (a pending word is written first)
//
//   rx handshake: a character transfers on a cycle where rx_valid && rx_ready.
//   rx_ready is high exactly while a load is in progress (DATA or ADDR state).
//   The sender may hold rx_valid/rx_data for any number of cycles; a character
//   offered in the same cycle as start is dropped.
//
//   Optional feature macro: HEX_IMAGE_WRITER_CHECKSUM_EN
//     defined     : checksum accumulates the XOR of every written word
//     not defined : checksum is tied to zero and no checksum logic exists
//
//   state_dbg exposes the FSM state encoding for checkers.

module hex_image_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_cnt,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [1:0]            state_dbg
);

  // Digits per word and the width of the per-word digit counter.
  localparam int ND  = (DATA_WIDTH + 3) / 4;
  localparam int DCW = $clog2(ND + 1) + 1;

  localparam logic [DCW-1:0]        ND_CNT   = DCW'(ND);
  localparam logic [DCW-1:0]        DCNT_ONE = DCW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH:0]   WC_ONE   = (ADDR_WIDTH + 1)'(1);

  // FSM encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ADDR = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;       // next write address
  logic [DATA_WIDTH-1:0] acc;        // word being assembled
  logic [DCW-1:0]        dcnt;       // digits seen in the current word (saturates at ND)
  logic [ADDR_WIDTH-1:0] aacc;       // address being assembled after '@'
  logic                  adig;       // at least one address digit seen

  // Character classification.
  logic       is_hex;
  logic       is_sep;
  logic       is_at;
  logic       is_end;
  logic [3:0] nib;

  // Handshake and write-request decode.
  logic accept;
  logic wr_req;
  logic wr_last;

  // Classify the offered character and compute its nibble value.
  always_comb begin
    is_hex = 1'b0;
    is_sep = 1'b0;
    is_at  = 1'b0;
    is_end = 1'b0;
    nib    = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
                 (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
      // 'a'/'A' have low nibble 1, so adding 9 maps them onto 10..15.
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end else if (rx_data == 8'h20 || rx_data == 8'h09 ||
                 rx_data == 8'h0D || rx_data == 8'h0A) begin
      is_sep = 1'b1;
    end else if (rx_data == 8'h40) begin
      is_at = 1'b1;
    end else if (rx_data == 8'h23) begin
      is_end = 1'b1;
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy      = (state == S_DATA) || (state == S_ADDR);
    rx_ready  = busy;
    done      = (state == S_DONE);
    state_dbg = state;
  end

  // A character transfers only when no start pulse overrides it. A pending
  // word is flushed by any terminator in DATA; the write into the last RAM
  // location ends the load.
  always_comb begin
    accept  = rx_valid && rx_ready && !start;
    wr_req  = accept && (state == S_DATA) && (dcnt != '0) &&
              (is_sep || is_end || is_at);
    wr_last = wr_req && (addr == ADDR_MAX);
  end

  // Main FSM, word/address assembly, write strobe and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      acc      <= '0;
      dcnt     <= '0;
      aacc     <= '0;
      adig     <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      err      <= 1'b0;
      word_cnt <= '0;
    end else if (start) begin
      state    <= S_DATA;
      addr     <= '0;
      acc      <= '0;
      dcnt     <= '0;
      aacc     <= '0;
      adig     <= 1'b0;
      we       <= 1'b0;
      err      <= 1'b0;
      word_cnt <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE: begin
          // Characters are never accepted while idle.
        end

        S_DATA: begin
          if (accept) begin
            if (is_hex) begin
              acc <= DATA_WIDTH'({acc, nib});
              if (dcnt == ND_CNT) begin
                err <= 1'b1;
              end else begin
                dcnt <= dcnt + DCNT_ONE;
              end
            end else if (is_sep || is_end || is_at) begin
              if (wr_req) begin
                we       <= 1'b1;
                waddr    <= addr;
                wdata    <= acc;
                addr     <= addr + ADDR_ONE;
                word_cnt <= word_cnt + WC_ONE;
                acc      <= '0;
                dcnt     <= '0;
              end
              if (wr_last || is_end) begin
                state <= S_DONE;
              end else if (is_at) begin
                state <= S_ADDR;
                aacc  <= '0;
                adig  <= 1'b0;
              end
            end else begin
              // Unknown character: flag it and carry on.
              err <= 1'b1;
            end
          end
        end

        S_ADDR: begin
          if (accept) begin
            if (is_hex) begin
              aacc <= ADDR_WIDTH'({aacc, nib});
              adig <= 1'b1;
            end else if (is_sep) begin
              // An empty address field leaves the write address untouched.
              if (adig) begin
                addr <= aacc;
              end else begin
                err <= 1'b1;
              end
              state <= S_DATA;
            end else if (is_end) begin
              state <= S_DONE;
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef HEX_IMAGE_WRITER_CHECKSUM_EN
  // Running XOR of every word presented on the write port.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      checksum <= '0;
    end else if (we) begin
      checksum <= checksum ^ wdata;
    end
  end
`else
  // Checksum feature compiled out.
  always_comb begin
    checksum = '0;
  end
`endif

endmodule

// File: tb/tb_hex_image_writer.sv
// Testbench for hex_image_writer.
//   Stimulus drives ASCII streams (directed and random); a reference parser
//   predicts every RAM write and the end-of-image pulse with the cycle at
//   which it must appear and pushes them into queues. An independent monitor
//   pops and compares whenever the DUT strobes we or done.

module tb_hex_image_writer;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int ND = (DW + 3) / 4;
  localparam int EW = 32 + AW + DW;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_cnt;
  logic [DW-1:0] checksum;
  logic [1:0]    state_dbg;

  hex_image_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt),
    .checksum (checksum),
    .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp;
  int n_bad;

  logic [EW-1:0] exp_q[$];    // {cycle, addr, data} of each expected write
  logic [31:0]   done_q[$];   // cycle of each expected done pulse

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- reference parser
  bit            m_active;   // load in progress, characters are taken
  bit            m_inaddr;   // between '@' and its separator
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_acc;
  int            m_nd;
  logic [AW-1:0] m_aacc;
  bit            m_adig;
  bit            m_err;
  logic [AW:0]   m_wc;
  logic [DW-1:0] m_cks;

  task automatic model_clear();
    m_active = 0; m_inaddr = 0; m_addr = '0; m_acc = '0; m_nd = 0;
    m_aacc = '0; m_adig = 0; m_err = 0; m_wc = '0; m_cks = '0;
  endtask

  task automatic model_start();
    model_clear();
    m_active = 1;
  endtask

  // kind: 0 hex, 1 separator, 2 '@', 3 '#', 4 anything else
  task automatic classify(input logic [7:0] c, output int kind, output int val);
    kind = 4;
    val  = 0;
    if (c >= "0" && c <= "9") begin kind = 0; val = int'(c) - 48; end
    else if (c >= "a" && c <= "f") begin kind = 0; val = int'(c) - 97 + 10; end
    else if (c >= "A" && c <= "F") begin kind = 0; val = int'(c) - 65 + 10; end
    else if (c == " " || c == 8'h09 || c == 8'h0D || c == 8'h0A) kind = 1;
    else if (c == "@") kind = 2;
    else if (c == "#") kind = 3;
  endtask

  task automatic finish_load(input logic [31:0] ec);
    done_q.push_back(ec);
    m_active = 0;
    m_inaddr = 0;
  endtask

  task automatic emit_word(input logic [31:0] ec, output bit last);
    exp_q.push_back({ec, m_addr, m_acc});
`ifdef HEX_IMAGE_WRITER_CHECKSUM_EN
    m_cks = m_cks ^ m_acc;
`endif
    last   = (m_addr == {AW{1'b1}});
    m_addr = m_addr + 1'b1;
    m_wc   = m_wc + 1'b1;
    m_acc  = '0;
    m_nd   = 0;
  endtask

  // Process one accepted character; ec is the cycle its effects become visible.
  task automatic model_char(input logic [7:0] c, input logic [31:0] ec);
    int kind;
    int val;
    bit last;
    classify(c, kind, val);
    last = 0;
    if (!m_inaddr) begin
      case (kind)
        0: begin
          if (m_nd == ND) m_err = 1; else m_nd++;
          m_acc = (m_acc << 4) | DW'(val);
        end
        1, 2, 3: begin
          if (m_nd > 0) emit_word(ec, last);
          if (last || kind == 3) finish_load(ec);
          else if (kind == 2) begin m_inaddr = 1; m_aacc = '0; m_adig = 0; end
        end
        default: m_err = 1;
      endcase
    end else begin
      case (kind)
        0: begin m_aacc = (m_aacc << 4) | AW'(val); m_adig = 1; end
        1: begin
          if (m_adig) m_addr = m_aacc; else m_err = 1;
          m_inaddr = 0;
        end
        3: finish_load(ec);
        default: m_err = 1;
      endcase
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [31:0]   d;
    if (!rst) begin
      if (we) begin
        if (exp_q.size() == 0) begin
          check("we_unexpected", {32'd0, 32'(waddr)}, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("we_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
          check("waddr", 64'(waddr), 64'(e[AW+DW-1:DW]));
          check("wdata", 64'(wdata), 64'(e[DW-1:0]));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 64'(cyc), 64'hFFFF_FFFF);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d));
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic send_char(input logic [7:0] c, input bit gaps);
    @(negedge clk);
    if (gaps) begin
      while ($urandom_range(0, 4) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = c;
    check("rx_ready", 64'(rx_ready), 64'(m_active));
    if (m_active) model_char(c, 32'(cyc + 1));
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) send_char(s[i], gaps);
  endtask

  task automatic do_start(input bit junk);
    @(negedge clk);
    start    = 1'b1;
    rx_valid = junk;
    rx_data  = "#";       // would end the load if it were not dropped
    model_start();
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err"}, 64'(err), 64'(m_err));
    check({tag, "_word_cnt"}, 64'(word_cnt), 64'(m_wc));
    check({tag, "_checksum"}, 64'(checksum), 64'(m_cks));
    check({tag, "_busy"}, 64'(busy), 64'(m_active));
  endtask

  function automatic string rand_stream();
    string s;
    string hx;
    string sp;
    int    ntok;
    int    k;
    int    n;
    s    = "";
    hx   = "0123456789abcdefABCDEF";
    sp   = " \t\r\n";
    ntok = $urandom_range(1, 12);
    for (int t = 0; t < ntok; t++) begin
      k = $urandom_range(0, 9);
      if (k < 6) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) s = $sformatf("%s%c", s, hx[$urandom_range(0, 21)]);
        s = $sformatf("%s%c", s, sp[$urandom_range(0, 3)]);
      end else if (k < 8) begin
        s = {s, "@"};
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) s = $sformatf("%s%c", s, hx[$urandom_range(0, 21)]);
        s = $sformatf("%s%c", s, sp[$urandom_range(0, 3)]);
      end else if (k == 8) begin
        s = {s, ($urandom_range(0, 1) == 0) ? "z" : ","};
      end else begin
        s = $sformatf("%s%c", s, sp[$urandom_range(0, 3)]);
      end
    end
    if ($urandom_range(0, 1) == 1) s = $sformatf("%s%c", s, hx[$urandom_range(0, 21)]);
    return {s, "#"};
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    string big;
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we", 64'(we), 0);
    check("rst_waddr", 64'(waddr), 0);
    check("rst_wdata", 64'(wdata), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_rx_ready", 64'(rx_ready), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err), 0);
    check("rst_word_cnt", 64'(word_cnt), 0);
    check("rst_checksum", 64'(checksum), 0);
    rst = 1'b0;

    // Characters offered while idle are ignored
    send_str("12 ", 0);
    settle();

    // Basic image
    do_start(0);
    send_str("12 AB\n#", 1);
    settle();
    check_status("t1");
    check("t1_wc_const", 64'(word_cnt), 2);

    // Address record near the top of memory, back-to-back characters
    do_start(0);
    send_str("@3F0 5 6#", 0);
    settle();
    check_status("t2");

    // Overlong word and bad characters; err sticky until start
    do_start(0);
    send_str("123 zz 4#", 1);
    settle();
    check_status("t3");
    check("t3_err_const", 64'(err), 1);
    repeat (3) @(negedge clk);
    check("t3_err_held", 64'(err), 1);
    do_start(0);
    @(negedge clk);
    check("t3_err_cleared", 64'(err), 0);
    send_str("#", 0);
    settle();

    // Restart mid-stream with a same-cycle character that must be dropped
    do_start(0);
    send_str("11 22 ", 1);
    do_start(1);
    send_str("33#", 1);
    settle();
    check_status("t5");
    check("t5_wc_const", 64'(word_cnt), 1);

    // Checksum image
    do_start(0);
    send_str("0F F0 AA#", 1);
    settle();
    check_status("t6");
`ifdef HEX_IMAGE_WRITER_CHECKSUM_EN
    check("t6_cks_const", 64'(checksum), 64'h55);
`else
    check("t6_cks_const", 64'(checksum), 0);
`endif

    // Write to the last address via '@' ends the load; rest is refused
    do_start(0);
    send_str("@3FE 1 2 3 #", 1);
    settle();
    check_status("wrap_at");

    // Full memory fill: 1024 words, load ends with the write to 0x3FF
    do_start(0);
    big = "";
    for (int i = 0; i < 1024; i++) big = {big, "7 "};
    send_str(big, 0);
    send_str("7 8 ", 1);
    settle();
    check_status("fill");
    check("fill_wc_const", 64'(word_cnt), 1024);

    // Random images
    repeat (30) begin
      do_start(1'($urandom_range(0, 1)));
      send_str(rand_stream(), 1);
      settle();
      check_status("rand");
    end

    // Reset in the middle of a load clears everything
    do_start(0);
    send_str("0F F0 1", 1);
    settle();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_err", 64'(err), 0);
    check("mid_rst_word_cnt", 64'(word_cnt), 0);
    check("mid_rst_checksum", 64'(checksum), 0);
    check("mid_rst_we", 64'(we), 0);
    rst = 1'b0;
    @(negedge clk);
    check_status("after_rst");

    // Every predicted event must have been observed
    check("exp_q_empty", 64'(exp_q.size()), 0);
    check("done_q_empty", 64'(done_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
